// File: rtl/sigmoid_pkg.sv
// Shared constants and error-flag indices for the sigmoid datapath and its result buffer.
package sigmoid_pkg;

    localparam int DATA_W  = 16;
    localparam int SIG_LAT = 5;

    typedef enum logic [1:0] {
        ERR_OVF    = 2'd0,
        ERR_NOCRED = 2'd1,
        ERR_SPUR   = 2'd2
    } err_idx_e;

endpackage

// File: rtl/sigmoid_sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head; pushes into a full FIFO are dropped
// unless a pop happens in the same cycle.
module sigmoid_sync_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [CW-1:0]     count,
    output logic              ovf
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW-1:0]     rd_ptr_nxt_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_nxt_s;
    logic              m_valid_r;
    logic [DATA_W-1:0] m_data_r;
    logic [DATA_W-1:0] head_nxt_s;
    logic              pop_s;
    logic              full_s;
    logic              push_acc_s;
    logic              ovf_s;

    // Next-state for pointers, occupancy and the show-ahead head value.
    always_comb begin
        pop_s      = m_valid_r && pop_ready;
        full_s     = (count_r == FULL_C);
        push_acc_s = push && (!full_s || pop_s);
        ovf_s      = push && full_s && !pop_s;

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_acc_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        // The slot being written this cycle becomes the head when it lands on the next read pointer.
        if (push_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = push_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_W{1'b0}};
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r  <= rd_ptr_nxt_s;
            count_r   <= count_nxt_s;
            m_valid_r <= (count_nxt_s != {CW{1'b0}});
            if (count_nxt_s != {CW{1'b0}}) begin
                m_data_r <= head_nxt_s;
            end
        end
    end

    assign m_valid = m_valid_r;
    assign m_data  = m_data_r;
    assign count   = count_r;
    assign ovf     = ovf_s;

endmodule

// File: rtl/sigmoid_result_fifo.sv
// Result buffer behind the non-stallable sigmoid pipeline: captures every result, hands out
// issue credits so a result always finds a free slot, and keeps sticky error flags.
module sigmoid_result_fifo #(
    parameter  int DATA_W   = sigmoid_pkg::DATA_W,
    parameter  int DEPTH    = 8,
    parameter  int PIPE_LAT = sigmoid_pkg::SIG_LAT,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ok,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CW-1:0]     count,
    output logic [CW-1:0]     in_flight,
    output logic [2:0]        err
);

    import sigmoid_pkg::*;

    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    if ((DEPTH < PIPE_LAT + 1) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_cfg_err
        $error("sigmoid_result_fifo: DEPTH must be a power of two and at least PIPE_LAT+1");
    end

    logic [CW-1:0] count_s;
    logic          ovf_s;
    logic [CW-1:0] in_flight_r;
    logic [CW-1:0] in_flight_nxt_s;
    logic [2:0]    err_r;
    logic [2:0]    err_nxt_s;
    logic [CW:0]   credit_sum_s;
    logic          issue_ok_s;
    logic          spur_s;
    logic          nocred_s;

    sigmoid_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid),
        .push_data (res_data),
        .pop_ready (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .count     (count_s),
        .ovf       (ovf_s)
    );

    // Credit check, in-flight tracking and error-flag next state.
    always_comb begin
        // Only registered state and rst feed the credit so m_ready/res_valid never reach issue_ok.
        credit_sum_s = {1'b0, count_s} + {1'b0, in_flight_r};
        issue_ok_s   = rst && (credit_sum_s < DEPTH_C);
        spur_s       = res_valid && (in_flight_r == {CW{1'b0}});
        nocred_s     = issue_valid && !issue_ok_s;

        case ({issue_valid, res_valid})
            2'b10: begin
                if (in_flight_r != FULL_C) begin
                    in_flight_nxt_s = in_flight_r + CW'(1);
                end else begin
                    in_flight_nxt_s = in_flight_r;
                end
            end
            2'b01: begin
                if (in_flight_r != {CW{1'b0}}) begin
                    in_flight_nxt_s = in_flight_r - CW'(1);
                end else begin
                    in_flight_nxt_s = in_flight_r;
                end
            end
            default: in_flight_nxt_s = in_flight_r;
        endcase

        err_nxt_s             = err_r;
        err_nxt_s[ERR_OVF]    = err_r[ERR_OVF] | ovf_s;
        err_nxt_s[ERR_NOCRED] = err_r[ERR_NOCRED] | nocred_s;
        err_nxt_s[ERR_SPUR]   = err_r[ERR_SPUR] | spur_s;
    end

    // In-flight counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_flight_r <= {CW{1'b0}};
            err_r       <= 3'b000;
        end else begin
            in_flight_r <= in_flight_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign issue_ok  = issue_ok_s;
    assign count     = count_s;
    assign in_flight = in_flight_r;
    assign err       = err_r;

endmodule

// File: tb/tb_sigmoid_result_fifo.sv
// Directed bench for sigmoid_result_fifo; a 5-stage delay line stands in for the sigmoid pipeline.
module tb_sigmoid_result_fifo;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_ok;
    logic        res_valid;
    logic [15:0] res_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [3:0]  count;
    logic [3:0]  in_flight;
    logic [2:0]  err;

    int n_assert = 0;
    int n_fail   = 0;

    logic        pv [5];
    logic [15:0] pd [5];

    sigmoid_result_fifo #(
        .DATA_W   (16),
        .DEPTH    (8),
        .PIPE_LAT (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ok    (issue_ok),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .in_flight   (in_flight),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 5; i++) begin
            pv[i] = 1'b0;
            pd[i] = 16'h0000;
        end
    endtask

    // Apply inputs at the falling edge, clock once, return at the next falling edge.
    task automatic tick(input logic iss, input logic [15:0] d, input logic rdy,
                        input logic fr, input logic [15:0] fd);
        issue_valid = iss;
        m_ready     = rdy;
        if (fr) begin
            res_valid = 1'b1;
            res_data  = fd;
        end else begin
            res_valid = pv[4];
            res_data  = pd[4];
        end
        for (int i = 4; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = iss;
        pd[0] = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue while credit allows with the consumer stalled; returns the number of issues.
    task automatic fill(input logic [15:0] base, output int issued);
        logic iss;
        issued = 0;
        for (int k = 0; k < 20; k++) begin
            iss = issue_ok;
            tick(iss, 16'(base + 16'(issued)), 1'b0, 1'b0, 16'h0000);
            if (iss) issued++;
        end
    endtask

    initial begin
        int   issued;
        int   rcv;
        int   gaps;
        logic iss;
        logic rdy;

        rst = 1'b0;
        issue_valid = 1'b0;
        res_valid = 1'b0;
        res_data = 16'h0000;
        m_ready = 1'b0;
        clear_pipe();
        @(negedge clk);

        // 1. Reset
        for (int k = 0; k < 3; k++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 16'h0000);
        chk("rst_count", count, 4'd0);
        chk("rst_in_flight", in_flight, 4'd0);
        chk("rst_err", err, 3'b000);
        chk("rst_issue_ok", issue_ok, 1'b0);
        rst = 1'b1;
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("rel_issue_ok", issue_ok, 1'b1);

        // 2. Single sample through the pipeline
        tick(1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000);
        chk("single_in_flight_0", in_flight, 4'd1);
        for (int k = 1; k < 5; k++) begin
            tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
            chk("single_in_flight", in_flight, 4'd1);
            chk("single_not_yet", m_valid, 1'b0);
        end
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("single_m_valid", m_valid, 1'b1);
        chk("single_m_data", m_data, 16'h8000);
        chk("single_in_flight_done", in_flight, 4'd0);
        chk("single_count", count, 4'd1);
        tick(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk("single_pop_count", count, 4'd0);
        chk("single_pop_valid", m_valid, 1'b0);

        // 3. Backpressure: credits cap issues at DEPTH
        fill(16'h0001, issued);
        chk("bp_issues", 32'(issued), 32'd8);
        chk("bp_issue_ok", issue_ok, 1'b0);
        chk("bp_count", count, 4'd8);
        chk("bp_in_flight", in_flight, 4'd0);
        chk("bp_err", err, 3'b000);
        for (int i = 1; i <= 8; i++) begin
            chk("bp_drain_valid", m_valid, 1'b1);
            chk("bp_drain_data", m_data, 32'(i));
            tick(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
            if (i == 1) chk("bp_credit_back", issue_ok, 1'b1);
        end
        chk("bp_empty", count, 4'd0);
        chk("bp_empty_valid", m_valid, 1'b0);

        // 4. Steady stream of 100 samples
        issued = 0; rcv = 0; gaps = 0;
        for (int k = 0; k < 130 && rcv < 100; k++) begin
            if (m_valid) begin
                chk("stream_data", m_data, 32'h0100 + 32'(rcv));
                rcv++;
            end else if (rcv > 0) begin
                gaps++;
            end
            chk("stream_count_le1", (count <= 4'd1), 1'b1);
            iss = (issued < 100) && issue_ok;
            tick(iss, 16'(32'h0100 + 32'(issued)), 1'b1, 1'b0, 16'h0000);
            if (iss) issued++;
        end
        chk("stream_rcv", 32'(rcv), 32'd100);
        chk("stream_gaps", 32'(gaps), 32'd0);
        chk("stream_end_count", count, 4'd0);

        // 5. Error flags
        fill(16'h0011, issued);
        chk("e_fill_count", count, 4'd8);
        chk("e_no_credit", issue_ok, 1'b0);
        tick(1'b1, 16'hABCD, 1'b0, 1'b0, 16'h0000);
        chk("e_nocred_err", err, 3'b010);
        chk("e_nocred_inflight", in_flight, 4'd1);
        for (int k = 0; k < 5; k++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("e_ovf_err", err, 3'b011);
        chk("e_ovf_count", count, 4'd8);
        chk("e_ovf_head", m_data, 16'h0011);
        chk("e_ovf_inflight", in_flight, 4'd0);
        tick(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234);
        chk("e_spur_err", err, 3'b111);
        chk("e_spur_inflight", in_flight, 4'd0);
        chk("e_spur_count", count, 4'd8);
        for (int i = 0; i < 8; i++) begin
            chk("e_drain_data", m_data, 32'h0011 + 32'(i));
            tick(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        end
        for (int k = 0; k < 3; k++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("e_sticky", err, 3'b111);
        chk("e_drained", count, 4'd0);

        // 6. Wrap with stuttering consumer, then reset mid-operation
        issued = 0; rcv = 0;
        for (int k = 0; k < 200 && rcv < 20; k++) begin
            rdy = (k % 2 == 0);
            if (m_valid && rdy) begin
                chk("wrap_data", m_data, 32'h2000 + 32'(rcv));
                rcv++;
            end
            iss = (issued < 20) && issue_ok;
            tick(iss, 16'(32'h2000 + 32'(issued)), rdy, 1'b0, 16'h0000);
            if (iss) issued++;
        end
        chk("wrap_rcv", 32'(rcv), 32'd20);
        for (int k = 0; k < 5; k++) tick(1'b1, 16'(16'h3000 + 16'(k)), 1'b0, 1'b0, 16'h0000);
        for (int k = 0; k < 8; k++) tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("mid_count", count, 4'd5);
        chk("mid_head", m_data, 16'h3000);
        rst = 1'b0;
        clear_pipe();
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("mid_rst_count", count, 4'd0);
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_err", err, 3'b000);
        chk("mid_rst_inflight", in_flight, 4'd0);
        chk("mid_rst_issue_ok", issue_ok, 1'b0);
        rst = 1'b1;
        tick(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("mid_rel_issue_ok", issue_ok, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
